// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - shared types and constants for the nibble-serial ALU sequencer
// Contents: func_e (slice function codes), state_e (sequencer states),
//           WIDTH / NIBBLES / NIB_W, and nib_of() nibble extraction helper.
package xalu_pkg;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = 4;
    localparam int NIB_W   = 4;

    typedef enum logic [2:0] {
        FN_ADD   = 3'd0,
        FN_AND   = 3'd1,
        FN_OR    = 3'd2,
        FN_XOR   = 3'd3,
        FN_PASSA = 3'd4,
        FN_PASSB = 3'd5,
        FN_SHR   = 3'd6,
        FN_SHL   = 3'd7
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [NIB_W-1:0] nib_of(input logic [WIDTH-1:0] word,
                                                input logic [1:0]       sel);
        return word[{sel, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/xalu_nib_sel.sv
// rtl/xalu_nib_sel.sv - selects one 4-bit nibble of a 16-bit word by index
// Ports: word (16-bit source), sel (nibble index 0..3, 0 = LSB), nib (selected nibble).
module xalu_nib_sel
    import xalu_pkg::*;
(
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       sel,
    output logic [NIB_W-1:0] nib
);

    assign nib = nib_of(word, sel);

endmodule

// File: rtl/xalu_nibble_seq.sv
// rtl/xalu_nibble_seq.sv - sequences a 16-bit operation through an external 4-bit ALU slice
// Ports: clk, rst_n (sync active-low); in_valid/in_ready request handshake with
//        op_a, op_b, func, com (and cin when XALU_SEQ_CIN_EN is defined);
//        out_valid/out_ready result handshake with result, carry, zero, neg_zero, equ;
//        alu_da, alu_db, alu_f, alu_com, alu_ci_right, alu_ci_left drive the slice;
//        alu_d, alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ return from it.
// Build option: XALU_SEQ_CIN_EN adds the cin port seeding the carry at accept.
module xalu_nibble_seq
    import xalu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       func,
    input  logic             com,
`ifdef XALU_SEQ_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic [NIB_W-1:0] alu_da,
    output logic [NIB_W-1:0] alu_db,
    output logic [2:0]       alu_f,
    output logic             alu_com,
    output logic             alu_ci_right,
    output logic             alu_ci_left,
    input  logic [NIB_W-1:0] alu_d,
    input  logic             alu_co_left,
    input  logic             alu_co_right,
    input  logic             alu_zero,
    input  logic             alu_neg_zero,
    input  logic             alu_equ
);

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             shr_q;
    logic [1:0]       idx;

    logic             cin_eff;
    logic             accept;
    logic             shr_in;
    logic [1:0]       idx_next;
    logic [1:0]       active;
    logic [1:0]       sel;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic             carry_next;

`ifdef XALU_SEQ_CIN_EN
    assign cin_eff = cin;
`else
    assign cin_eff = 1'b0;
`endif

    assign accept   = in_valid & in_ready;
    assign shr_in   = (func == FN_SHR);
    assign idx_next = idx + 2'd1;
    // Shift-right walks MSB first, so the nibble index is mirrored (3 - idx == ~idx).
    assign active   = shr_q ? ~idx : idx;
    // Right shift propagates the carry downward out of the slice's right edge.
    assign carry_next = shr_q ? alu_co_right : alu_co_left;

    // The slice inputs are registered, so the selector looks one nibble ahead:
    // at accept it picks the first nibble from the live operands, during RUN
    // it picks the following nibble from the latched operands.
    always_comb begin
        src_a = a_q;
        src_b = b_q;
        sel   = shr_q ? ~idx_next : idx_next;
        if (state == ST_IDLE) begin
            src_a = op_a;
            src_b = op_b;
            sel   = shr_in ? 2'd3 : 2'd0;
        end
    end

    xalu_nib_sel u_sel_a (
        .word (src_a),
        .sel  (sel),
        .nib  (nib_a)
    );

    xalu_nib_sel u_sel_b (
        .word (src_b),
        .sel  (sel),
        .nib  (nib_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            result       <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            neg_zero     <= 1'b0;
            equ          <= 1'b0;
            idx          <= 2'd0;
            a_q          <= '0;
            b_q          <= '0;
            shr_q        <= 1'b0;
            alu_da       <= '0;
            alu_db       <= '0;
            alu_f        <= 3'd0;
            alu_com      <= 1'b0;
            alu_ci_right <= 1'b0;
            alu_ci_left  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q          <= op_a;
                        b_q          <= op_b;
                        shr_q        <= shr_in;
                        carry        <= cin_eff;
                        idx          <= 2'd0;
                        // Flags are ANDed per nibble, so start from all-true.
                        zero         <= 1'b1;
                        neg_zero     <= 1'b1;
                        equ          <= 1'b1;
                        in_ready     <= 1'b0;
                        alu_da       <= nib_a;
                        alu_db       <= nib_b;
                        alu_f        <= func;
                        alu_com      <= com;
                        alu_ci_right <= shr_in ? 1'b0 : cin_eff;
                        alu_ci_left  <= shr_in ? cin_eff : 1'b0;
                        state        <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    result[{active, 2'b00} +: NIB_W] <= alu_d;
                    carry    <= carry_next;
                    zero     <= zero & alu_zero;
                    neg_zero <= neg_zero & alu_neg_zero;
                    equ      <= equ & alu_equ;
                    if (idx == 2'd3) begin
                        out_valid    <= 1'b1;
                        alu_da       <= '0;
                        alu_db       <= '0;
                        alu_f        <= 3'd0;
                        alu_com      <= 1'b0;
                        alu_ci_right <= 1'b0;
                        alu_ci_left  <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        idx          <= idx_next;
                        alu_da       <= nib_a;
                        alu_db       <= nib_b;
                        alu_ci_right <= shr_q ? 1'b0 : carry_next;
                        alu_ci_left  <= shr_q ? carry_next : 1'b0;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= 2'd0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// tb/tb_xalu_nibble_seq.sv - directed self-checking bench for xalu_nibble_seq with a 4-bit slice model
module tb_xalu_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  func;
    logic        com;
`ifdef XALU_SEQ_CIN_EN
    logic        cin;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic        neg_zero;
    logic        equ;
    logic [3:0]  alu_da;
    logic [3:0]  alu_db;
    logic [2:0]  alu_f;
    logic        alu_com;
    logic        alu_ci_right;
    logic        alu_ci_left;
    logic [3:0]  alu_d;
    logic        alu_co_left;
    logic        alu_co_right;
    logic        alu_zero;
    logic        alu_neg_zero;
    logic        alu_equ;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xalu_nibble_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .func         (func),
        .com          (com),
`ifdef XALU_SEQ_CIN_EN
        .cin          (cin),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .neg_zero     (neg_zero),
        .equ          (equ),
        .alu_da       (alu_da),
        .alu_db       (alu_db),
        .alu_f        (alu_f),
        .alu_com      (alu_com),
        .alu_ci_right (alu_ci_right),
        .alu_ci_left  (alu_ci_left),
        .alu_d        (alu_d),
        .alu_co_left  (alu_co_left),
        .alu_co_right (alu_co_right),
        .alu_zero     (alu_zero),
        .alu_neg_zero (alu_neg_zero),
        .alu_equ      (alu_equ)
    );

    // Behavioural 4-bit slice
    logic [4:0] m_sum;
    logic [3:0] m_raw;
    logic [3:0] m_d;
    logic       m_col;
    logic       m_cor;

    always_comb begin
        m_sum = 5'd0;
        m_raw = 4'd0;
        m_col = 1'b0;
        m_cor = 1'b0;
        case (alu_f)
            3'd0: begin
                m_sum = {1'b0, alu_da} + {1'b0, alu_db} + {4'd0, alu_ci_right};
                m_raw = m_sum[3:0];
                m_col = m_sum[4];
            end
            3'd1: m_raw = alu_da & alu_db;
            3'd2: m_raw = alu_da | alu_db;
            3'd3: m_raw = alu_da ^ alu_db;
            3'd4: m_raw = alu_da;
            3'd5: m_raw = alu_db;
            3'd6: begin
                m_raw = {alu_ci_left, alu_da[3:1]};
                m_cor = alu_da[0];
            end
            default: begin
                m_raw = {alu_da[2:0], alu_ci_right};
                m_col = alu_da[3];
            end
        endcase
        m_d = alu_com ? ~m_raw : m_raw;
    end

    assign alu_d        = m_d;
    assign alu_co_left  = m_col;
    assign alu_co_right = m_cor;
    assign alu_zero     = (m_d == 4'h0);
    assign alu_neg_zero = (m_d == 4'hF);
    assign alu_equ      = (alu_da == alu_db);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for out_valid; lat counts edges from the
    // accept edge (edge 1) to the edge after which out_valid is seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                         input logic c, input logic ci, output int lat);
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        func     = f;
        com      = c;
`ifdef XALU_SEQ_CIN_EN
        cin      = ci;
`else
        if (ci) $display("note: carry-in ignored in this build");
`endif
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk);
            lat++;
            #1 in_valid = 1'b0;
        end while (!out_valid && lat < 20);
    endtask

    task automatic ack_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_ov_clr"}, out_valid, 1'b0);
        chk({tag, "_rdy_set"}, in_ready, 1'b1);
    endtask

    int         lat;
    logic [15:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        func      = '0;
        com       = 1'b0;
`ifdef XALU_SEQ_CIN_EN
        cin       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_carry", carry, 1'b0);
        chk("rst_flags", {zero, neg_zero, equ}, 3'b000);
        chk("idle_alu_d", {alu_da, alu_db}, 8'h00);
        chk("idle_alu_ctl", {alu_f, alu_com, alu_ci_right, alu_ci_left}, 6'd0);

        // ADD 0x1234 + 0x0FCD
        do_op(16'h1234, 16'h0FCD, 3'd0, 1'b0, 1'b0, lat);
        chk("add1_latency", lat, 5);
        chk("add1_result", result, 16'h2201);
        chk("add1_carry", carry, 1'b0);
        chk("add1_zero", zero, 1'b0);
        ack_op("add1");
        chk("idle_alu_after", {alu_da, alu_db, alu_f}, 11'd0);

        // ADD 0xFFFF + 0x0001 wraps to zero
        do_op(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0, lat);
        chk("add2_result", result, 16'h0000);
        chk("add2_carry", carry, 1'b1);
        chk("add2_zero", zero, 1'b1);
        chk("add2_equ", equ, 1'b0);
        ack_op("add2");

`ifdef XALU_SEQ_CIN_EN
        do_op(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, lat);
        chk("addcin_result", result, 16'h0001);
        chk("addcin_carry", carry, 1'b0);
        ack_op("addcin");
`endif

        do_op(16'h8001, 16'h0000, 3'd6, 1'b0, 1'b0, lat);
        chk("shr_result", result, 16'h4000);
        chk("shr_carry", carry, 1'b1);
        ack_op("shr");

        do_op(16'h8001, 16'h0000, 3'd7, 1'b0, 1'b0, lat);
        chk("shl_result", result, 16'h0002);
        chk("shl_carry", carry, 1'b1);
        ack_op("shl");

        do_op(16'hA5A5, 16'hA5A5, 3'd3, 1'b0, 1'b0, lat);
        chk("xor_result", result, 16'h0000);
        chk("xor_flags", {zero, neg_zero, equ}, 3'b101);
        ack_op("xor");

        do_op(16'hA5A5, 16'hA5A5, 3'd3, 1'b1, 1'b0, lat);
        chk("xorc_result", result, 16'hFFFF);
        chk("xorc_flags", {zero, neg_zero, equ}, 3'b011);
        ack_op("xorc");

        do_op(16'hF0F0, 16'h3C3C, 3'd1, 1'b0, 1'b0, lat);
        chk("and_result", result, 16'h3030);
        chk("and_carry", carry, 1'b0);
        ack_op("and");

        // Hold off out_ready for 3 cycles with a pending request
        do_op(16'h1234, 16'h5678, 3'd5, 1'b0, 1'b0, lat);
        chk("passb_result", result, 16'h5678);
        held = result;
        in_valid = 1'b1;
        op_a     = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_result", result, held);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        chk("hold_exit_ready", in_ready, 1'b1);
        chk("hold_exit_ov", out_valid, 1'b0);
        chk("hold_exit_result", result, held);
        @(negedge clk);
        chk("hold_no_accept", in_ready, 1'b1);

        // Reset during RUN cycle 2
        @(negedge clk);
        op_a     = 16'h1234;
        op_b     = 16'h0FCD;
        func     = 3'd0;
        com      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("rr_run_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rr_in_ready", in_ready, 1'b1);
        chk("rr_out_valid", out_valid, 1'b0);
        chk("rr_result", result, 16'h0000);
        chk("rr_carry", carry, 1'b0);
        repeat (6) @(posedge clk);
        #1 chk("rr_no_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
